pipe_hazard_ctrl: RTL and testbench

Sequencing controller for the 5-stage pipeline's stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB) and PC. It resolves branch and jump redirects from the EX/MEM stage outputs, inserts load-use bubbles, and freezes the pipeline while a data-memory access is outstanding. A watchdog ends runaway memory waits in a sticky error state. It has no datapath storage beyond its FSM and counters; all enables and flushes are driven into the existing stage registers.

---
 rtl/pipe_hazard_ctrl.sv | 163 ++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing controller: branch/jump redirect, load-use bubble, memory-wait freeze
// with a sticky watchdog. Performance counters are built only when PIPE_HAZARD_PERF_EN is defined.
module pipe_hazard_ctrl #(
    parameter int unsigned WAIT_MAX = 16,
    parameter int unsigned CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             idex_mem_read,
    input  logic [4:0]       idex_rt,
    input  logic [4:0]       ifid_rs,
    input  logic [4:0]       ifid_rt,
    input  logic             exmem_branch,
    input  logic             exmem_zero_1,
    input  logic             exmem_zero_2,
    input  logic             exmem_beq_bne,
    input  logic             exmem_jump,
    input  logic [31:0]      exmem_b_addr,
    input  logic [31:0]      exmem_j_addr,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic [1:0]       pc_sel,
    output logic [31:0]      pc_target,
    output logic             ifid_write,
    output logic             idex_write,
    output logic             exmem_write,
    output logic             memwb_write,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             exmem_flush,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERROR    = 2'd2
    } state_t;

    localparam logic [7:0] WAIT_LIMIT = 8'(WAIT_MAX);

    state_t     state_reg;
    logic [7:0] wait_cnt_reg;
    logic       mem_timeout_reg;

    logic taken;
    logic redirect;
    logic load_use;
    logic mem_busy;

    assign taken    = exmem_branch & ((~exmem_beq_bne & exmem_zero_1) | (exmem_beq_bne & exmem_zero_2));
    assign redirect = taken | exmem_jump;
    assign load_use = idex_mem_read & (idex_rt != 5'd0) &
                      ((idex_rt == ifid_rs) | (idex_rt == ifid_rt));
    assign mem_busy = mem_req & ~mem_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg       <= RUN;
            wait_cnt_reg    <= 8'd0;
            mem_timeout_reg <= 1'b0;
        end else begin
            case (state_reg)
                RUN: begin
                    if (mem_busy) begin
                        state_reg    <= MEM_WAIT;
                        wait_cnt_reg <= 8'd1;
                    end
                end
                MEM_WAIT: begin
                    // A ready arriving on the limit cycle still completes normally
                    if (mem_ready) begin
                        state_reg    <= RUN;
                        wait_cnt_reg <= 8'd0;
                    end else if (wait_cnt_reg == WAIT_LIMIT) begin
                        state_reg       <= ERROR;
                        mem_timeout_reg <= 1'b1;
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg + 8'd1;
                    end
                end
                default: begin
                    state_reg       <= ERROR;
                    mem_timeout_reg <= 1'b1;
                end
            endcase
        end
    end

    assign mem_timeout = mem_timeout_reg;

    always_comb begin
        pc_write    = 1'b0;
        ifid_write  = 1'b0;
        idex_write  = 1'b0;
        exmem_write = 1'b0;
        memwb_write = 1'b0;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;
        pc_sel      = 2'd0;
        pc_target   = 32'd0;
        if (!rst) begin
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
        end else if (state_reg == RUN && !mem_busy) begin
            if (redirect) begin
                pc_write    = 1'b1;
                ifid_write  = 1'b1;
                idex_write  = 1'b1;
                exmem_write = 1'b1;
                memwb_write = 1'b1;
                ifid_flush  = 1'b1;
                idex_flush  = 1'b1;
                exmem_flush = 1'b1;
                pc_sel      = exmem_jump ? 2'd2 : 2'd1;
                pc_target   = exmem_jump ? exmem_j_addr : exmem_b_addr;
            end else if (load_use) begin
                idex_write  = 1'b1;
                exmem_write = 1'b1;
                memwb_write = 1'b1;
                idex_flush  = 1'b1;
            end else begin
                pc_write    = 1'b1;
                ifid_write  = 1'b1;
                idex_write  = 1'b1;
                exmem_write = 1'b1;
                memwb_write = 1'b1;
            end
        end
    end

`ifdef PIPE_HAZARD_PERF_EN
    logic [CNT_W-1:0] stall_cnt_reg;
    logic [CNT_W-1:0] flush_cnt_reg;

    // ifid_flush outside reset is high only on an applied redirect
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_reg <= '0;
            flush_cnt_reg <= '0;
        end else begin
            if (!pc_write && state_reg != ERROR && stall_cnt_reg != '1) begin
                stall_cnt_reg <= stall_cnt_reg + 1'b1;
            end
            if (ifid_flush && flush_cnt_reg != '1) begin
                flush_cnt_reg <= flush_cnt_reg + 1'b1;
            end
        end
    end

    assign stall_cnt = stall_cnt_reg;
    assign flush_cnt = flush_cnt_reg;
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios plus randomized stimulus
// compared cycle by cycle against a rule-level reference model.
module tb_pipe_hazard_ctrl;

    localparam int WAIT_MAX = 4;
    localparam int CNT_W    = 32;
`ifdef PIPE_HAZARD_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    typedef struct packed {
        logic        mr;
        logic [4:0]  rt;
        logic [4:0]  rs;
        logic [4:0]  frt;
        logic        br;
        logic        z1;
        logic        z2;
        logic        bb;
        logic        jp;
        logic [31:0] ba;
        logic [31:0] ja;
        logic        req;
        logic        rdy;
    } stim_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             idex_mem_read;
    logic [4:0]       idex_rt, ifid_rs, ifid_rt;
    logic             exmem_branch, exmem_zero_1, exmem_zero_2, exmem_beq_bne, exmem_jump;
    logic [31:0]      exmem_b_addr, exmem_j_addr;
    logic             mem_req, mem_ready;
    logic             pc_write;
    logic [1:0]       pc_sel;
    logic [31:0]      pc_target;
    logic             ifid_write, idex_write, exmem_write, memwb_write;
    logic             ifid_flush, idex_flush, exmem_flush, mem_timeout;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    pipe_hazard_ctrl #(.WAIT_MAX(WAIT_MAX), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .idex_mem_read(idex_mem_read), .idex_rt(idex_rt), .ifid_rs(ifid_rs), .ifid_rt(ifid_rt),
        .exmem_branch(exmem_branch), .exmem_zero_1(exmem_zero_1), .exmem_zero_2(exmem_zero_2),
        .exmem_beq_bne(exmem_beq_bne), .exmem_jump(exmem_jump),
        .exmem_b_addr(exmem_b_addr), .exmem_j_addr(exmem_j_addr),
        .mem_req(mem_req), .mem_ready(mem_ready),
        .pc_write(pc_write), .pc_sel(pc_sel), .pc_target(pc_target),
        .ifid_write(ifid_write), .idex_write(idex_write), .exmem_write(exmem_write),
        .memwb_write(memwb_write), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
        .exmem_flush(exmem_flush), .mem_timeout(mem_timeout),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    // {pc_write, ifid_w, idex_w, exmem_w, memwb_w, ifid_f, idex_f, exmem_f, mem_timeout}
    logic [8:0] obs_ctl;
    assign obs_ctl = {pc_write, ifid_write, idex_write, exmem_write, memwb_write,
                      ifid_flush, idex_flush, exmem_flush, mem_timeout};

    int n_vec  = 0;
    int n_miss = 0;

    // Reference model: pipeline mode as plain integers (0 running, 1 waiting on memory, 2 dead)
    int               m_mode;
    int               m_misses;
    logic [CNT_W-1:0] m_stall, m_flush;
    logic [8:0]       e_ctl;
    logic [1:0]       e_sel;
    logic [31:0]      e_tgt;
    logic [CNT_W-1:0] e_stall, e_flush;

    stim_t sq[$];
    bit    rq[$];

    function automatic stim_t quiet();
        stim_t s;
        s = '0;
        return s;
    endfunction

    function automatic stim_t rand_stim();
        stim_t s;
        s.mr  = 1'($urandom_range(0, 1));
        s.rt  = 5'($urandom_range(0, 3));
        s.rs  = 5'($urandom_range(0, 3));
        s.frt = 5'($urandom_range(0, 3));
        s.br  = 1'($urandom_range(0, 1));
        s.z1  = 1'($urandom_range(0, 1));
        s.z2  = 1'($urandom_range(0, 1));
        s.bb  = 1'($urandom_range(0, 1));
        s.jp  = ($urandom_range(0, 3) == 0);
        s.ba  = $urandom;
        s.ja  = $urandom;
        s.req = ($urandom_range(0, 3) == 0);
        s.rdy = 1'($urandom_range(0, 1));
        return s;
    endfunction

    task automatic model_reset();
        m_mode   = 0;
        m_misses = 0;
        m_stall  = '0;
        m_flush  = '0;
    endtask

    task automatic drive(input stim_t s, input bit r);
        idex_mem_read = s.mr;  idex_rt = s.rt;  ifid_rs = s.rs;  ifid_rt = s.frt;
        exmem_branch = s.br;   exmem_zero_1 = s.z1;  exmem_zero_2 = s.z2;
        exmem_beq_bne = s.bb;  exmem_jump = s.jp;
        exmem_b_addr = s.ba;   exmem_j_addr = s.ja;
        mem_req = s.req;       mem_ready = s.rdy;
        rst = r;
        if (!r) model_reset();
    endtask

    task automatic expect_now();
        bit taken, redir, lu, busy;
        taken = exmem_branch && (exmem_beq_bne ? exmem_zero_2 : exmem_zero_1);
        redir = taken || exmem_jump;
        lu    = idex_mem_read && (idex_rt != 0) && (idex_rt == ifid_rs || idex_rt == ifid_rt);
        busy  = mem_req && !mem_ready;
        e_sel = 2'd0;
        e_tgt = 32'd0;
        if (!rst)                      e_ctl = 9'b00000_111_0;
        else if (m_mode != 0 || busy)  e_ctl = {8'b0, m_mode == 2};
        else if (redir) begin
            e_ctl = 9'b11111_111_0;
            e_sel = exmem_jump ? 2'd2 : 2'd1;
            e_tgt = exmem_jump ? exmem_j_addr : exmem_b_addr;
        end
        else if (lu)                   e_ctl = 9'b00111_010_0;
        else                           e_ctl = 9'b11111_000_0;
        e_stall = PERF ? m_stall : '0;
        e_flush = PERF ? m_flush : '0;
    endtask

    task automatic step_model();
        expect_now();
        if (!rst) begin
            model_reset();
        end else begin
            if (m_mode != 2 && !e_ctl[8] && m_stall != '1) m_stall = m_stall + 1;
            if (e_ctl[5] && e_ctl[3] && m_flush != '1)      m_flush = m_flush + 1;
            if (m_mode == 0) begin
                if (mem_req && !mem_ready) begin
                    m_mode   = 1;
                    m_misses = 0;
                end
            end else if (m_mode == 1) begin
                if (mem_ready) m_mode = 0;
                else begin
                    m_misses++;
                    if (m_misses == WAIT_MAX) m_mode = 2;
                end
            end
        end
    endtask

    task automatic test_reset();
        sq.delete(); rq.delete();
        repeat (3) begin sq.push_back(rand_stim()); rq.push_back(1'b0); end
        repeat (2) begin sq.push_back(quiet());     rq.push_back(1'b1); end
        foreach (sq[i]) begin
            drive(sq[i], rq[i]);
            @(negedge clk); expect_now(); n_vec++;
            $display("reset     c%0d ctl=%b sel=%0d tgt=%h", i, obs_ctl, pc_sel, pc_target);
            if (obs_ctl !== e_ctl || pc_sel !== e_sel || pc_target !== e_tgt ||
                stall_cnt !== e_stall || flush_cnt !== e_flush) begin
                n_miss++;
                $display("FAIL reset c%0d: got ctl=%b sel=%0d tgt=%h st=%0d fl=%0d want ctl=%b sel=%0d tgt=%h st=%0d fl=%0d",
                         i, obs_ctl, pc_sel, pc_target, stall_cnt, flush_cnt, e_ctl, e_sel, e_tgt, e_stall, e_flush);
            end
            @(posedge clk); step_model(); #1;
        end
    endtask

    task automatic test_beq_taken();
        stim_t s;
        sq.delete(); rq.delete();
        s = quiet(); s.br = 1'b1; s.z1 = 1'b1; s.ba = 32'h40;
        sq.push_back(s);       rq.push_back(1'b1);
        sq.push_back(quiet()); rq.push_back(1'b1);
        foreach (sq[i]) begin
            drive(sq[i], rq[i]);
            @(negedge clk); expect_now(); n_vec++;
            $display("beq       c%0d ctl=%b sel=%0d tgt=%h fl=%0d", i, obs_ctl, pc_sel, pc_target, flush_cnt);
            if (obs_ctl !== e_ctl || pc_sel !== e_sel || pc_target !== e_tgt ||
                stall_cnt !== e_stall || flush_cnt !== e_flush) begin
                n_miss++;
                $display("FAIL beq c%0d: got ctl=%b sel=%0d tgt=%h st=%0d fl=%0d want ctl=%b sel=%0d tgt=%h st=%0d fl=%0d",
                         i, obs_ctl, pc_sel, pc_target, stall_cnt, flush_cnt, e_ctl, e_sel, e_tgt, e_stall, e_flush);
            end
            @(posedge clk); step_model(); #1;
        end
    endtask

    task automatic test_jump_rt0();
        stim_t s;
        sq.delete(); rq.delete();
        s = quiet(); s.br = 1'b1; s.bb = 1'b1; s.z2 = 1'b0; s.jp = 1'b1; s.ja = 32'h100; s.ba = 32'h55;
        sq.push_back(s); rq.push_back(1'b1);
        s = quiet(); s.mr = 1'b1; s.rt = 5'd0; s.rs = 5'd0;
        sq.push_back(s); rq.push_back(1'b1);
        sq.push_back(quiet()); rq.push_back(1'b1);
        foreach (sq[i]) begin
            drive(sq[i], rq[i]);
            @(negedge clk); expect_now(); n_vec++;
            $display("jump_rt0  c%0d ctl=%b sel=%0d tgt=%h", i, obs_ctl, pc_sel, pc_target);
            if (obs_ctl !== e_ctl || pc_sel !== e_sel || pc_target !== e_tgt ||
                stall_cnt !== e_stall || flush_cnt !== e_flush) begin
                n_miss++;
                $display("FAIL jump_rt0 c%0d: got ctl=%b sel=%0d tgt=%h st=%0d fl=%0d want ctl=%b sel=%0d tgt=%h st=%0d fl=%0d",
                         i, obs_ctl, pc_sel, pc_target, stall_cnt, flush_cnt, e_ctl, e_sel, e_tgt, e_stall, e_flush);
            end
            @(posedge clk); step_model(); #1;
        end
    endtask

    task automatic test_load_use();
        stim_t s;
        sq.delete(); rq.delete();
        s = quiet(); s.mr = 1'b1; s.rt = 5'd5; s.frt = 5'd5; s.rs = 5'd2;
        sq.push_back(s); rq.push_back(1'b1);
        s = quiet(); s.rs = 5'd2; s.frt = 5'd5;
        sq.push_back(s); rq.push_back(1'b1);
        sq.push_back(quiet()); rq.push_back(1'b1);
        foreach (sq[i]) begin
            drive(sq[i], rq[i]);
            @(negedge clk); expect_now(); n_vec++;
            $display("load_use  c%0d ctl=%b st=%0d", i, obs_ctl, stall_cnt);
            if (obs_ctl !== e_ctl || pc_sel !== e_sel || pc_target !== e_tgt ||
                stall_cnt !== e_stall || flush_cnt !== e_flush) begin
                n_miss++;
                $display("FAIL load_use c%0d: got ctl=%b sel=%0d tgt=%h st=%0d fl=%0d want ctl=%b sel=%0d tgt=%h st=%0d fl=%0d",
                         i, obs_ctl, pc_sel, pc_target, stall_cnt, flush_cnt, e_ctl, e_sel, e_tgt, e_stall, e_flush);
            end
            @(posedge clk); step_model(); #1;
        end
    endtask

    task automatic test_mem_wait_redirect();
        stim_t s;
        sq.delete(); rq.delete();
        s = quiet(); s.br = 1'b1; s.z1 = 1'b1; s.ba = 32'h80; s.req = 1'b1;
        sq.push_back(s); rq.push_back(1'b1);
        sq.push_back(s); rq.push_back(1'b1);
        s.rdy = 1'b1;
        sq.push_back(s); rq.push_back(1'b1);
        s.req = 1'b0; s.rdy = 1'b0;
        sq.push_back(s); rq.push_back(1'b1);
        sq.push_back(quiet()); rq.push_back(1'b1);
        foreach (sq[i]) begin
            drive(sq[i], rq[i]);
            @(negedge clk); expect_now(); n_vec++;
            $display("mem_wait  c%0d ctl=%b sel=%0d st=%0d", i, obs_ctl, pc_sel, stall_cnt);
            if (obs_ctl !== e_ctl || pc_sel !== e_sel || pc_target !== e_tgt ||
                stall_cnt !== e_stall || flush_cnt !== e_flush) begin
                n_miss++;
                $display("FAIL mem_wait c%0d: got ctl=%b sel=%0d tgt=%h st=%0d fl=%0d want ctl=%b sel=%0d tgt=%h st=%0d fl=%0d",
                         i, obs_ctl, pc_sel, pc_target, stall_cnt, flush_cnt, e_ctl, e_sel, e_tgt, e_stall, e_flush);
            end
            @(posedge clk); step_model(); #1;
        end
    endtask

    task automatic test_timeout();
        stim_t s;
        sq.delete(); rq.delete();
        sq.push_back(quiet()); rq.push_back(1'b0);
        s = quiet(); s.req = 1'b1;
        repeat (6) begin sq.push_back(s); rq.push_back(1'b1); end
        s.rdy = 1'b1;
        repeat (2) begin sq.push_back(s); rq.push_back(1'b1); end
        sq.push_back(quiet()); rq.push_back(1'b0);
        sq.push_back(quiet()); rq.push_back(1'b1);
        // ready on the limit cycle must win over the watchdog
        s = quiet(); s.req = 1'b1;
        repeat (WAIT_MAX) begin sq.push_back(s); rq.push_back(1'b1); end
        s.rdy = 1'b1;
        sq.push_back(s); rq.push_back(1'b1);
        repeat (2) begin sq.push_back(quiet()); rq.push_back(1'b1); end
        foreach (sq[i]) begin
            drive(sq[i], rq[i]);
            @(negedge clk); expect_now(); n_vec++;
            $display("timeout   c%0d ctl=%b to=%0d", i, obs_ctl, mem_timeout);
            if (obs_ctl !== e_ctl || pc_sel !== e_sel || pc_target !== e_tgt ||
                stall_cnt !== e_stall || flush_cnt !== e_flush) begin
                n_miss++;
                $display("FAIL timeout c%0d: got ctl=%b sel=%0d tgt=%h st=%0d fl=%0d want ctl=%b sel=%0d tgt=%h st=%0d fl=%0d",
                         i, obs_ctl, pc_sel, pc_target, stall_cnt, flush_cnt, e_ctl, e_sel, e_tgt, e_stall, e_flush);
            end
            @(posedge clk); step_model(); #1;
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            drive(rand_stim(), $urandom_range(0, 29) != 0);
            @(negedge clk); expect_now(); n_vec++;
            $display("random    c%0d rst=%0d ctl=%b sel=%0d tgt=%h", i, rst, obs_ctl, pc_sel, pc_target);
            if (obs_ctl !== e_ctl || pc_sel !== e_sel || pc_target !== e_tgt ||
                stall_cnt !== e_stall || flush_cnt !== e_flush) begin
                n_miss++;
                $display("FAIL random c%0d: got ctl=%b sel=%0d tgt=%h st=%0d fl=%0d want ctl=%b sel=%0d tgt=%h st=%0d fl=%0d",
                         i, obs_ctl, pc_sel, pc_target, stall_cnt, flush_cnt, e_ctl, e_sel, e_tgt, e_stall, e_flush);
            end
            @(posedge clk); step_model(); #1;
        end
    endtask

    initial begin
        drive(quiet(), 1'b0);
        #1;
        test_reset();
        test_beq_taken();
        test_jump_rt0();
        test_load_use();
        test_mem_wait_redirect();
        test_timeout();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
